// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the run controller: command codes, stop causes and
// FSM state encoding.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_SET_PC = 3'd1,
    CMD_RUN    = 3'd2,
    CMD_STEP   = 3'd3,
    CMD_SET_BP = 3'd4,
    CMD_CLR_BP = 3'd5,
    CMD_QUIT   = 3'd6,
    CMD_RSVD   = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    HALT_NONE = 2'd0,
    HALT_QUIT = 2'd1,
    HALT_BP   = 2'd2,
    HALT_STEP = 2'd3
  } halt_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

endpackage

// File: rtl/bp_match.sv
// Single hardware breakpoint: holds the breakpoint address and enable and
// flags a retire whose PC matches while enabled.
module bp_match (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_bp,
  input  logic        clr_bp,
  input  logic [31:0] set_adr,
  input  logic        retire,
  input  logic [31:0] retire_pc,
  output logic        hit
);

  logic [31:0] bp_adr_r;
  logic        bp_en_r;

  // Breakpoint storage; set wins if both strobes were ever raised together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_adr_r <= 32'h0000_0000;
      bp_en_r  <= 1'b0;
    end else if (set_bp) begin
      bp_adr_r <= set_adr;
      bp_en_r  <= 1'b1;
    end else if (clr_bp) begin
      bp_en_r  <= 1'b0;
    end
  end

  // Match against the stored address; the caller gates retire by state.
  always_comb begin
    if (retire && bp_en_r && (retire_pc == bp_adr_r)) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Debug run controller: accepts host commands, launches the CPU, counts
// single-step retires, watches a breakpoint and stops the CPU on request.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_code,
  input  logic [31:0]       cmd_data,
  input  logic              stall,
  input  logic              retire,
  input  logic [31:0]       retire_pc,
  output logic              cpu_start,
  output logic              quit_cmd,
  output logic [31:0]       start_adr,
  output logic              run_active,
  output logic [1:0]        halt_code,
  output logic [STEP_W-1:0] step_left
);

  localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
  localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

  state_e             state_r;
  logic               cmd_ready_r;
  logic               cpu_start_r;
  logic               quit_cmd_r;
  logic [31:0]        start_adr_r;
  logic               run_active_r;
  halt_e              halt_code_r;
  logic [STEP_W-1:0]  step_left_r;
  logic               step_mode_r;

  cmd_e               cmd_code_s;
  logic               cmd_acc_s;
  logic               set_bp_s;
  logic               clr_bp_s;
  logic               run_retire_s;
  logic               bp_hit_s;
  logic               step_dec_s;
  logic               step_done_s;
  logic [STEP_W-1:0]  step_cnt_s;

  assign cmd_code_s = cmd_e'(cmd_code);
  assign step_cnt_s = cmd_data[STEP_W-1:0];

  // Command handshake decode and retire qualification for the current state.
  always_comb begin
    cmd_acc_s    = cmd_valid & cmd_ready_r;
    run_retire_s = retire & (state_r == ST_RUN);
    if (cmd_acc_s) begin
      set_bp_s = (cmd_code_s == CMD_SET_BP);
      clr_bp_s = (cmd_code_s == CMD_CLR_BP);
    end else begin
      set_bp_s = 1'b0;
      clr_bp_s = 1'b0;
    end
    if (run_retire_s && step_mode_r && (step_left_r != STEP_ZERO)) begin
      step_dec_s  = 1'b1;
      step_done_s = (step_left_r == STEP_ONE);
    end else begin
      step_dec_s  = 1'b0;
      step_done_s = 1'b0;
    end
  end

  bp_match u_bp_match (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_bp    (set_bp_s),
    .clr_bp    (clr_bp_s),
    .set_adr   (cmd_data),
    .retire    (run_retire_s),
    .retire_pc (retire_pc),
    .hit       (bp_hit_s)
  );

  // Main FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cmd_ready_r  <= 1'b1;
      cpu_start_r  <= 1'b0;
      quit_cmd_r   <= 1'b0;
      start_adr_r  <= 32'h0000_0000;
      run_active_r <= 1'b0;
      halt_code_r  <= HALT_NONE;
      step_left_r  <= STEP_ZERO;
      step_mode_r  <= 1'b0;
    end else begin
      cpu_start_r <= 1'b0;
      quit_cmd_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_acc_s) begin
            case (cmd_code_s)
              CMD_SET_PC: start_adr_r <= cmd_data;
              CMD_RUN: begin
                step_mode_r  <= 1'b0;
                halt_code_r  <= HALT_NONE;
                state_r      <= ST_LAUNCH;
                cmd_ready_r  <= 1'b0;
                cpu_start_r  <= 1'b1;
                run_active_r <= 1'b1;
              end
              CMD_STEP: begin
                if (step_cnt_s != STEP_ZERO) begin
                  step_left_r  <= step_cnt_s;
                  step_mode_r  <= 1'b1;
                  halt_code_r  <= HALT_NONE;
                  state_r      <= ST_LAUNCH;
                  cmd_ready_r  <= 1'b0;
                  cpu_start_r  <= 1'b1;
                  run_active_r <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        ST_LAUNCH: begin
          state_r     <= ST_RUN;
          cmd_ready_r <= 1'b1;
        end
        ST_RUN: begin
          if (step_dec_s) begin
            step_left_r <= step_left_r - STEP_ONE;
          end
          if (cmd_acc_s && (cmd_code_s == CMD_QUIT)) begin
            halt_code_r <= HALT_QUIT;
            state_r     <= ST_STOP;
            cmd_ready_r <= 1'b0;
            quit_cmd_r  <= 1'b1;
          end else if (bp_hit_s) begin
            halt_code_r <= HALT_BP;
            state_r     <= ST_STOP;
            cmd_ready_r <= 1'b0;
            quit_cmd_r  <= 1'b1;
          end else if (step_done_s) begin
            halt_code_r <= HALT_STEP;
            state_r     <= ST_STOP;
            cmd_ready_r <= 1'b0;
            quit_cmd_r  <= 1'b1;
          end
        end
        ST_STOP: begin
          if (stall) begin
            state_r      <= ST_IDLE;
            cmd_ready_r  <= 1'b1;
            run_active_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          cmd_ready_r  <= 1'b1;
          run_active_r <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign cpu_start  = cpu_start_r;
  assign quit_cmd   = quit_cmd_r;
  assign start_adr  = start_adr_r;
  assign run_active = run_active_r;
  assign halt_code  = halt_code_r;
  assign step_left  = step_left_r;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller with hand-computed expectations.
module tb_run_controller;
  import run_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_code;
  logic [31:0] cmd_data;
  logic        stall;
  logic        retire;
  logic [31:0] retire_pc;
  logic        cpu_start;
  logic        quit_cmd;
  logic [31:0] start_adr;
  logic        run_active;
  logic [1:0]  halt_code;
  logic [15:0] step_left;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  run_controller #(.STEP_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_code   (cmd_code),
    .cmd_data   (cmd_data),
    .stall      (stall),
    .retire     (retire),
    .retire_pc  (retire_pc),
    .cpu_start  (cpu_start),
    .quit_cmd   (quit_cmd),
    .start_adr  (start_adr),
    .run_active (run_active),
    .halt_code  (halt_code),
    .step_left  (step_left)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] code, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_code  = code;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
    cmd_code  = 3'd0;
    cmd_data  = 32'h0;
  endtask

  // Leave STOP via stall, landing in IDLE
  task automatic release_stop();
    stall = 1'b1;
    tick();
    stall = 1'b0;
    check("stop_exit_ready", {31'h0, cmd_ready}, 32'h1);
    check("stop_exit_active", {31'h0, run_active}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_code = 3'd0; cmd_data = 32'h0;
    stall = 1'b0; retire = 1'b0; retire_pc = 32'h0;
    tick(); tick();
    check("rst_ready", {31'h0, cmd_ready}, 32'h1);
    check("rst_start", {31'h0, cpu_start}, 32'h0);
    check("rst_quit", {31'h0, quit_cmd}, 32'h0);
    check("rst_active", {31'h0, run_active}, 32'h0);
    check("rst_halt", {30'h0, halt_code}, 32'h0);
    check("rst_step", {16'h0, step_left}, 32'h0);
    check("rst_adr", start_adr, 32'h0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", {31'h0, cmd_ready}, 32'h1);

    // SET_PC then RUN, QUIT, stall exit
    send(CMD_SET_PC, 32'h0000_0100);
    check("setpc_adr", start_adr, 32'h100);
    check("setpc_nostart", {31'h0, cpu_start}, 32'h0);
    send(CMD_RUN, 32'h0);
    check("run_start_n1", {31'h0, cpu_start}, 32'h1);
    check("launch_ready", {31'h0, cmd_ready}, 32'h0);
    check("launch_active", {31'h0, run_active}, 32'h1);
    tick();
    check("run_start_once", {31'h0, cpu_start}, 32'h0);
    check("run_ready", {31'h0, cmd_ready}, 32'h1);
    tick(); tick();
    check("run_active_hold", {31'h0, run_active}, 32'h1);
    send(CMD_QUIT, 32'h0);
    check("quit_pulse", {31'h0, quit_cmd}, 32'h1);
    check("quit_halt", {30'h0, halt_code}, 32'h1);
    check("quit_nostart", {31'h0, cpu_start}, 32'h0);
    check("stop_ready", {31'h0, cmd_ready}, 32'h0);
    // RUN presented in STOP must not be consumed
    cmd_valid = 1'b1; cmd_code = CMD_RUN;
    tick();
    check("quit_pulse_end", {31'h0, quit_cmd}, 32'h0);
    check("stop_hold_ready", {31'h0, cmd_ready}, 32'h0);
    check("stop_hold_active", {31'h0, run_active}, 32'h1);
    cmd_valid = 1'b0; cmd_code = 3'd0;
    release_stop();
    tick();
    check("stop_run_not_taken", {31'h0, cpu_start}, 32'h0);
    check("stop_run_idle", {31'h0, run_active}, 32'h0);

    // STEP 3 with 5 retires
    send(CMD_STEP, 32'd3);
    check("step_start", {31'h0, cpu_start}, 32'h1);
    check("step_load", {16'h0, step_left}, 32'd3);
    tick();
    retire = 1'b1; retire_pc = 32'h1000;
    for (int i = 0; i < 5; i++) begin
      tick();
      retire_pc = retire_pc + 32'h4;
      if (i < 3) begin
        check($sformatf("step_cnt_%0d", i), {16'h0, step_left}, 32'(2 - i));
        check($sformatf("step_quit_%0d", i), {31'h0, quit_cmd}, (i == 2) ? 32'h1 : 32'h0);
      end else begin
        check($sformatf("step_ignored_%0d", i), {16'h0, step_left}, 32'h0);
        check($sformatf("step_noquit_%0d", i), {31'h0, quit_cmd}, 32'h0);
      end
    end
    retire = 1'b0;
    check("step_halt", {30'h0, halt_code}, 32'h3);
    release_stop();

    // Breakpoint at 0x40
    send(CMD_SET_BP, 32'h40);
    send(CMD_RUN, 32'h0);
    check("bp_halt_cleared", {30'h0, halt_code}, 32'h0);
    tick();
    retire = 1'b1;
    retire_pc = 32'h38; tick();
    check("bp_38_noquit", {31'h0, quit_cmd}, 32'h0);
    retire_pc = 32'h3C; tick();
    check("bp_3c_noquit", {31'h0, quit_cmd}, 32'h0);
    check("bp_3c_ready", {31'h0, cmd_ready}, 32'h1);
    retire_pc = 32'h40; tick();
    retire = 1'b0;
    check("bp_40_quit", {31'h0, quit_cmd}, 32'h1);
    check("bp_40_halt", {30'h0, halt_code}, 32'h2);
    release_stop();
    send(CMD_CLR_BP, 32'h0);
    send(CMD_RUN, 32'h0);
    tick();
    retire = 1'b1; retire_pc = 32'h40; tick();
    retire = 1'b0;
    check("clrbp_noquit", {31'h0, quit_cmd}, 32'h0);
    check("clrbp_running", {31'h0, cmd_ready}, 32'h1);
    check("clrbp_halt", {30'h0, halt_code}, 32'h0);
    check("adr_persist", start_adr, 32'h100);
    send(CMD_QUIT, 32'h0);
    release_stop();

    // STEP 1 with breakpoint and QUIT coinciding: QUIT wins
    send(CMD_SET_BP, 32'h80);
    send(CMD_STEP, 32'd1);
    tick();
    retire = 1'b1; retire_pc = 32'h80;
    send(CMD_QUIT, 32'h0);
    retire = 1'b0;
    check("coinc_halt", {30'h0, halt_code}, 32'h1);
    check("coinc_step", {16'h0, step_left}, 32'h0);
    check("coinc_quit", {31'h0, quit_cmd}, 32'h1);
    tick();
    check("coinc_quit_once", {31'h0, quit_cmd}, 32'h0);
    release_stop();

    // STEP 1 with breakpoint only: breakpoint beats step done
    send(CMD_STEP, 32'd1);
    tick();
    retire = 1'b1; retire_pc = 32'h80; tick();
    retire = 1'b0;
    check("bp_over_step_halt", {30'h0, halt_code}, 32'h2);
    check("bp_over_step_cnt", {16'h0, step_left}, 32'h0);
    release_stop();

    // STEP 0 and STEP with only upper bits set are NOPs
    send(CMD_STEP, 32'd0);
    check("step0_nostart", {31'h0, cpu_start}, 32'h0);
    check("step0_idle", {31'h0, run_active}, 32'h0);
    send(CMD_STEP, 32'h0001_0000);
    check("step_hi_nostart", {31'h0, cpu_start}, 32'h0);
    check("step_hi_ready", {31'h0, cmd_ready}, 32'h1);

    // Reset mid-run with step_left 7
    send(CMD_STEP, 32'd7);
    tick();
    check("mid_step7", {16'h0, step_left}, 32'd7);
    rst_n = 1'b0;
    #1;
    check("mrst_active", {31'h0, run_active}, 32'h0);
    check("mrst_step", {16'h0, step_left}, 32'h0);
    check("mrst_adr", start_adr, 32'h0);
    check("mrst_halt", {30'h0, halt_code}, 32'h0);
    check("mrst_ready", {31'h0, cmd_ready}, 32'h1);
    check("mrst_quit", {31'h0, quit_cmd}, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mrst_noquit_%0d", i), {31'h0, quit_cmd}, 32'h0);
    end
    check("mrst_ready_after", {31'h0, cmd_ready}, 32'h1);
    // Breakpoint enable was cleared: retire at PC 0 must not stop
    send(CMD_RUN, 32'h0);
    tick();
    retire = 1'b1; retire_pc = 32'h0; tick();
    retire = 1'b0;
    check("mrst_bp_cleared", {31'h0, quit_cmd}, 32'h0);
    send(CMD_QUIT, 32'h0);
    release_stop();

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
